// File: rtl/drop_sched.sv
// rtl/drop_sched.sv - falling-rectangle slot scheduler driven by mouse clicks and a gravity tick
// One shared y+vel adder walks the slots sequentially on each tick; clicks are parked in a one-deep pending register.
module drop_sched #(
  parameter int N_OBJ       = 4,
  parameter int TICK_CYCLES = 400000,
  parameter int FLOOR_Y     = 536,
  parameter int VMAX        = 63
) (
  input  logic                     clk40MHz,
  input  logic                     rst,
  input  logic                     mouse_left,
  input  logic                     mouse_right,
  input  logic [11:0]              mouse_xpos,
  input  logic [11:0]              mouse_ypos,
  input  logic [$clog2(N_OBJ)-1:0] rd_idx,
  output logic [11:0]              rd_xpos,
  output logic [11:0]              rd_ypos,
  output logic                     rd_active,
  output logic                     rd_landed,
  output logic [N_OBJ-1:0]         active_mask,
  output logic                     busy,
  output logic                     spawn_reject
);

  localparam int IW = $clog2(N_OBJ);
  localparam int VW = $clog2(VMAX + 1) + 1;
  localparam int CW = $clog2(TICK_CYCLES);

  typedef enum logic [1:0] {IDLE, UPDATE, CLEAR} state_t;

  state_t          state;
  logic [11:0]     x_q   [N_OBJ];
  logic [11:0]     y_q   [N_OBJ];
  logic [VW-1:0]   vel_q [N_OBJ];
  logic [N_OBJ-1:0] active_q, landed_q;
  logic [CW-1:0]   tick_cnt;
  logic            left_q, right_q;
  logic            pend;
  logic [11:0]     pend_x, pend_y;
  logic [IW-1:0]   idx;

  logic            left_edge, right_edge, tick, spawn_ok, falling;
  logic [IW-1:0]   free_idx;
  logic [12:0]     sum;
  logic [11:0]     y_new;
  logic [VW-1:0]   v_new;

  assign left_edge   = mouse_left & ~left_q;
  assign right_edge  = mouse_right & ~right_q;
  assign tick        = (tick_cnt == CW'(TICK_CYCLES - 1));
  assign spawn_ok    = (mouse_ypos < 12'(FLOOR_Y)) && !(&active_q) && !pend;
  assign falling     = |(active_q & ~landed_q);
  assign active_mask = active_q;

  always_comb begin
    free_idx = '0;
    for (int i = N_OBJ - 1; i >= 0; i--)
      if (!active_q[i]) free_idx = IW'(i);
  end

  // Position moves by the pre-increment velocity and clamps at the floor.
  always_comb begin
    sum   = {1'b0, y_q[idx]} + 13'(vel_q[idx]);
    y_new = (sum >= 13'(FLOOR_Y)) ? 12'(FLOOR_Y) : sum[11:0];
    v_new = (vel_q[idx] >= VW'(VMAX)) ? VW'(VMAX) : vel_q[idx] + 1'b1;
  end

  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      state        <= IDLE;
      active_q     <= '0;
      landed_q     <= '0;
      tick_cnt     <= '0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      pend         <= 1'b0;
      pend_x       <= '0;
      pend_y       <= '0;
      idx          <= '0;
      rd_xpos      <= '0;
      rd_ypos      <= '0;
      rd_active    <= 1'b0;
      rd_landed    <= 1'b0;
      busy         <= 1'b0;
      spawn_reject <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        vel_q[i] <= '0;
      end
    end else begin
      left_q    <= mouse_left;
      right_q   <= mouse_right;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      rd_xpos   <= x_q[rd_idx];
      rd_ypos   <= y_q[rd_idx];
      rd_active <= active_q[rd_idx];
      rd_landed <= landed_q[rd_idx];

      // A simultaneous right edge drops the click silently.
      spawn_reject <= left_edge && !right_edge && !spawn_ok;
      if (left_edge && !right_edge && spawn_ok) begin
        pend   <= 1'b1;
        pend_x <= mouse_xpos;
        pend_y <= mouse_ypos;
      end

      case (state)
        IDLE: begin
          if (right_edge) begin
            state <= CLEAR;
            busy  <= 1'b1;
          end else if (pend) begin
            x_q[free_idx]      <= pend_x;
            y_q[free_idx]      <= pend_y;
            vel_q[free_idx]    <= '0;
            active_q[free_idx] <= 1'b1;
            landed_q[free_idx] <= 1'b0;
            pend               <= 1'b0;
          end else if (tick && falling) begin
            idx   <= '0;
            state <= UPDATE;
            busy  <= 1'b1;
          end
        end
        UPDATE: begin
          if (right_edge) begin
            state <= CLEAR;
          end else begin
            if (active_q[idx] && !landed_q[idx]) begin
              y_q[idx] <= y_new;
              if (y_new == 12'(FLOOR_Y)) begin
                landed_q[idx] <= 1'b1;
                vel_q[idx]    <= '0;
              end else begin
                vel_q[idx] <= v_new;
              end
            end
            if (idx == IW'(N_OBJ - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        CLEAR: begin
          active_q <= '0;
          landed_q <= '0;
          pend     <= 1'b0;
          for (int i = 0; i < N_OBJ; i++) begin
            x_q[i]   <= '0;
            y_q[i]   <= '0;
            vel_q[i] <= '0;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drop_sched.sv
// tb/tb_drop_sched.sv - directed bench for drop_sched
// Instance a uses VMAX=63, instance b uses VMAX=3; both tick every 10 cycles.
module tb_drop_sched;

  logic clk40MHz = 1'b0;
  always #5 clk40MHz = ~clk40MHz;

  logic        rst;
  logic        mouse_left, mouse_right;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic [1:0]  rd_idx;
  logic [11:0] rd_xpos, rd_ypos;
  logic        rd_active, rd_landed, busy, spawn_reject;
  logic [3:0]  active_mask;

  logic        mouse_left_b, mouse_right_b;
  logic [11:0] mouse_xpos_b, mouse_ypos_b;
  logic [1:0]  rd_idx_b;
  logic [11:0] rd_xpos_b, rd_ypos_b;
  logic        rd_active_b, rd_landed_b, busy_b, spawn_reject_b;
  logic [3:0]  active_mask_b;

  drop_sched #(.N_OBJ(4), .TICK_CYCLES(10), .FLOOR_Y(536), .VMAX(63)) dut_a (
    .clk40MHz(clk40MHz), .rst(rst), .mouse_left(mouse_left), .mouse_right(mouse_right),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .rd_idx(rd_idx),
    .rd_xpos(rd_xpos), .rd_ypos(rd_ypos), .rd_active(rd_active), .rd_landed(rd_landed),
    .active_mask(active_mask), .busy(busy), .spawn_reject(spawn_reject));

  drop_sched #(.N_OBJ(4), .TICK_CYCLES(10), .FLOOR_Y(536), .VMAX(3)) dut_b (
    .clk40MHz(clk40MHz), .rst(rst), .mouse_left(mouse_left_b), .mouse_right(mouse_right_b),
    .mouse_xpos(mouse_xpos_b), .mouse_ypos(mouse_ypos_b), .rd_idx(rd_idx_b),
    .rd_xpos(rd_xpos_b), .rd_ypos(rd_ypos_b), .rd_active(rd_active_b), .rd_landed(rd_landed_b),
    .active_mask(active_mask_b), .busy(busy_b), .spawn_reject(spawn_reject_b));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic click(input bit sel, input int x, input int y, output logic rej);
    @(negedge clk40MHz);
    if (sel) begin mouse_left_b = 1'b1; mouse_xpos_b = 12'(x); mouse_ypos_b = 12'(y); end
    else     begin mouse_left   = 1'b1; mouse_xpos   = 12'(x); mouse_ypos   = 12'(y); end
    @(negedge clk40MHz);
    rej = sel ? spawn_reject_b : spawn_reject;
    mouse_left = 1'b0;
    mouse_left_b = 1'b0;
    @(negedge clk40MHz);
  endtask

  task automatic read_slot(input bit sel, input int i, output logic [11:0] y, output logic l);
    @(negedge clk40MHz);
    if (sel) rd_idx_b = 2'(i); else rd_idx = 2'(i);
    @(negedge clk40MHz);
    y = sel ? rd_ypos_b : rd_ypos;
    l = sel ? rd_landed_b : rd_landed;
  endtask

  task automatic read_full(input int i, output logic [11:0] x, output logic [11:0] y,
                           output logic a, output logic l);
    @(negedge clk40MHz);
    rd_idx = 2'(i);
    @(negedge clk40MHz);
    x = rd_xpos; y = rd_ypos; a = rd_active; l = rd_landed;
  endtask

  // Waits for a pass to start and returns its length in cycles (0 on timeout).
  task automatic wait_pass(input bit sel, output int n);
    bit found = 0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk40MHz);
      if (sel ? busy_b : busy) begin found = 1; break; end
    end
    if (found) begin
      n = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk40MHz);
        if (!(sel ? busy_b : busy)) break;
        n++;
      end
    end
  endtask

  task automatic clear_a();
    @(negedge clk40MHz); mouse_right = 1'b1;
    @(negedge clk40MHz); mouse_right = 1'b0;
    @(negedge clk40MHz);
  endtask

  logic [11:0] rx, ry;
  logic        ra, rl, rej;
  int          n;
  bit          saw_busy, found;
  int          exp_y [9] = '{500, 501, 503, 506, 510, 515, 521, 528, 536};
  int          my, mv;

  initial begin
    rst = 1'b1;
    mouse_left = 0; mouse_right = 0; mouse_xpos = 0; mouse_ypos = 0; rd_idx = 0;
    mouse_left_b = 0; mouse_right_b = 0; mouse_xpos_b = 0; mouse_ypos_b = 0; rd_idx_b = 0;
    repeat (3) @(negedge clk40MHz);
    check("rst_mask", active_mask, 0);
    check("rst_busy", busy, 0);
    check("rst_reject", spawn_reject, 0);
    check("rst_rd_y", rd_ypos, 0);
    check("rst_rd_active", rd_active, 0);
    check("rst_mask_b", active_mask_b, 0);
    rst = 1'b0;

    // Single drop from y=500 to the floor.
    click(0, 100, 500, rej);
    check("t1_rej", rej, 0);
    check("t1_mask", active_mask, 4'b0001);
    read_full(0, rx, ry, ra, rl);
    check("t1_x", rx, 100);
    check("t1_y", ry, 500);
    check("t1_active", ra, 1);
    check("t1_landed0", rl, 0);
    for (int k = 0; k < 9; k++) begin
      wait_pass(0, n);
      if (k == 0) check("t1_pass_len", n, 4);
      read_slot(0, 0, ry, rl);
      check($sformatf("t1_y_tick%0d", k + 1), ry, exp_y[k]);
    end
    check("t1_landed", rl, 1);
    saw_busy = 0;
    repeat (40) begin @(negedge clk40MHz); saw_busy |= busy; end
    check("t1_no_pass_landed", saw_busy, 0);
    read_full(0, rx, ry, ra, rl);
    check("t1_y_hold", ry, 536);
    check("t1_x_hold", rx, 100);

    // Refused clicks at and below the floor; boundary just above accepted.
    click(0, 50, 536, rej);
    check("t2_rej_floor", rej, 1);
    check("t2_mask_floor", active_mask, 4'b0001);
    click(0, 50, 4000, rej);
    check("t2_rej_4000", rej, 1);
    check("t2_mask_4000", active_mask, 4'b0001);
    click(0, 60, 535, rej);
    check("t2_rej_535", rej, 0);
    check("t2_mask_535", active_mask, 4'b0011);

    // Clear, then fill all four slots.
    @(negedge clk40MHz); mouse_right = 1'b1;
    @(negedge clk40MHz); mouse_right = 1'b0;
    check("t3_clear_busy", busy, 1);
    @(negedge clk40MHz);
    check("t3_clear_mask", active_mask, 0);
    check("t3_clear_idle", busy, 0);
    for (int i = 0; i < 4; i++) begin
      click(0, i * 100, i * 10, rej);
      check($sformatf("t3_rej%0d", i), rej, 0);
      repeat (6) @(negedge clk40MHz);
    end
    check("t3_mask_full", active_mask, 4'b1111);
    click(0, 400, 40, rej);
    check("t3_rej_full", rej, 1);
    wait_pass(0, n);
    check("t3_pass_len", n, 4);

    // Click on the first UPDATE cycle is served after the pass.
    clear_a();
    click(0, 10, 0, rej);
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk40MHz);
      if (busy) begin found = 1; break; end
    end
    check("t4_found", found, 1);
    n = 1;
    mouse_left = 1'b1; mouse_xpos = 200; mouse_ypos = 100;
    @(negedge clk40MHz);
    rej = spawn_reject;
    mouse_left = 1'b0;
    for (int i = 0; i < 20 && busy; i++) begin
      n++;
      @(negedge clk40MHz);
    end
    check("t4_rej", rej, 0);
    check("t4_pass_len", n, 4);
    check("t4_mask_before", active_mask, 4'b0001);
    @(negedge clk40MHz);
    check("t4_mask_after", active_mask, 4'b0011);
    read_slot(0, 1, ry, rl);
    check("t4_y_spawn", ry, 100);
    wait_pass(0, n);
    read_slot(0, 1, ry, rl);
    check("t4_y_tick1", ry, 100);
    wait_pass(0, n);
    read_slot(0, 1, ry, rl);
    check("t4_y_tick2", ry, 101);

    // Right edge while the pass is on slot 1.
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk40MHz);
      if (busy) begin found = 1; break; end
    end
    check("t5_found", found, 1);
    @(negedge clk40MHz);
    mouse_right = 1'b1;
    @(negedge clk40MHz);
    mouse_right = 1'b0;
    check("t5_clear_busy", busy, 1);
    check("t5_mask_pre", active_mask, 4'b0011);
    @(negedge clk40MHz);
    check("t5_mask", active_mask, 0);
    check("t5_busy", busy, 0);

    // Simultaneous left and right edges: right wins, no reject.
    @(negedge clk40MHz);
    mouse_left = 1'b1; mouse_right = 1'b1; mouse_xpos = 7; mouse_ypos = 100;
    @(negedge clk40MHz);
    check("t6_rej", spawn_reject, 0);
    check("t6_busy", busy, 1);
    mouse_left = 1'b0; mouse_right = 1'b0;
    @(negedge clk40MHz);
    check("t6_mask", active_mask, 0);
    repeat (3) @(negedge clk40MHz);
    check("t6_mask_late", active_mask, 0);

    // Long fall with velocity capped at 3.
    click(1, 5, 0, rej);
    check("t7_rej", rej, 0);
    check("t7_mask", active_mask_b, 4'b0001);
    my = 0; mv = 0;
    for (int k = 1; k <= 181; k++) begin
      wait_pass(1, n);
      my = (my + mv >= 536) ? 536 : my + mv;
      mv = (my == 536) ? 0 : ((mv + 1 > 3) ? 3 : mv + 1);
      read_slot(1, 0, ry, rl);
      check($sformatf("t7_y_tick%0d", k), ry, my);
      if (k == 4) check("t7_y_tick4_const", ry, 6);
      if (k == 180) begin
        check("t7_y_tick180", ry, 534);
        check("t7_landed_180", rl, 0);
      end
    end
    check("t7_y_final", ry, 536);
    check("t7_landed", rl, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
